// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control - multi-cycle control FSM for the 8-bit processor
//
// Fetches each instruction over the single shared memory port, holds it in
// the instruction register, and sequences the datapath (PC, register file,
// ALU source, writeback and address muxes) one state per cycle. The same
// memory port serves both instruction fetch and lw/sw data accesses.
//
// Instruction format: op=ir[7:6], rs=ir[5:4], rt=ir[3:2], rd/imm2=ir[1:0]
//   00 add, 01 lw, 10 sw, 11 j (6-bit PC-relative offset)
//
// Parameters:
//   MEM_TIMEOUT  cycles allowed waiting for mem_ready in FETCH/MEM
//   CNT_WIDTH    width of the retired-instruction counter
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   run                keep executing (sampled at IDLE exit and done cycle)
//   mem_rdata          memory read data (instruction byte during fetch)
//   mem_ready          memory access completes this cycle
//   mem_req, mem_we    memory request / write strobe
//   addr_sel           memory address mux: 0 = PC, 1 = ALU result
//   ir                 instruction register
//   ext_data           sign extender input, always ir[5:0]
//   ext_is_6bits       sign extender width select (j uses 6-bit offset)
//   alu_src_imm        ALU B operand = extended immediate
//   reg_we, wb_sel     register write enable, writeback mux (1 = memory)
//   dst_sel            destination register index
//   pc_we, pc_src      PC write enable, PC mux (0 = PC+1, 1 = PC+offset)
//   instr_done         one-cycle pulse on the final cycle of an instruction
//   instr_count        retired instructions, wraps
//   mem_err            sticky memory-timeout flag
//   state              current FSM state, for debug
// ---------------------------------------------------------------------------
module mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic [7:0]           ir,
  output logic [5:0]           ext_data,
  output logic                 ext_is_6bits,
  output logic                 alu_src_imm,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic [1:0]           dst_sel,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 mem_err,
  output logic [2:0]           state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t            cur_state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_ir;
  logic              timeout;
  logic              wait_expired;
  logic [1:0]        op;

  assign op           = ir[7:6];
  assign state        = cur_state;
  assign ext_data     = ir[5:0];
  assign ext_is_6bits = (op == OP_J);

  // The current cycle is the last one allowed without mem_ready; a ready
  // arriving on this very cycle still wins over the timeout.
  assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state and control decode. Every control defaults to 0 so that any
  // state not driving a signal leaves it inactive; all outputs depend only on
  // the current state, the held instruction and mem_ready.
  always_comb begin
    next_state  = cur_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    dst_sel     = 2'b00;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    instr_done  = 1'b0;
    load_ir     = 1'b0;
    timeout     = 1'b0;

    case (cur_state)
      IDLE: begin
        if (run && !mem_err) begin
          next_state = FETCH;
        end
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir    = 1'b1;
          pc_we      = 1'b1;
          next_state = DECODE;
        end else if (wait_expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end

      DECODE: begin
        // Jumps finish here: the PC was already incremented during fetch,
        // so the offset is added to PC+1.
        if (op == OP_J) begin
          pc_we      = 1'b1;
          pc_src     = 1'b1;
          instr_done = 1'b1;
          next_state = run ? FETCH : IDLE;
        end else begin
          next_state = EXEC;
        end
      end

      EXEC: begin
        alu_src_imm = (op != OP_ADD);
        next_state  = (op == OP_ADD) ? WB : MEM;
      end

      MEM: begin
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        alu_src_imm = 1'b1;
        mem_we      = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            instr_done = 1'b1;
            next_state = run ? FETCH : IDLE;
          end else begin
            next_state = WB;
          end
        end else if (wait_expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end

      WB: begin
        reg_we     = 1'b1;
        wb_sel     = (op == OP_LW);
        dst_sel    = (op == OP_ADD) ? ir[1:0] : ir[3:2];
        instr_done = 1'b1;
        next_state = run ? FETCH : IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Instruction register: only a completed fetch may replace it, so the
  // sign extender inputs stay stable for the rest of the instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= 8'h00;
    end else if (load_ir) begin
      ir <= mem_rdata;
    end
  end

  // Memory wait counter. Any state change clears it, which covers every
  // entry into FETCH or MEM; it then counts cycles spent without mem_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (next_state != cur_state) begin
      wait_cnt <= '0;
    end else if ((cur_state == FETCH || cur_state == MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (instr_done) begin
      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // Sticky timeout flag; only reset clears it, and IDLE refuses to start
  // while it is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control - scoreboard bench for mc_control
//
// The stimulus process pushes the hand-computed final-cycle response of each
// instruction into a queue; the monitor pops and compares whenever the DUT
// pulses instr_done. A memory responder answers mem_req with a programmable
// number of wait cycles per access.
// ---------------------------------------------------------------------------
module tb_mc_control;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic [7:0] ir;
  logic [5:0] ext_data;
  logic       ext_is_6bits;
  logic       alu_src_imm;
  logic       reg_we;
  logic       wb_sel;
  logic [1:0] dst_sel;
  logic       pc_we;
  logic       pc_src;
  logic       instr_done;
  logic [7:0] instr_count;
  logic       mem_err;
  logic [2:0] state;

  typedef struct {
    logic [7:0] instr;
    int         fd;
    int         md;
    bit         keep;
    logic [2:0] st;
    logic       reg_we;
    logic       wb_sel;
    logic [1:0] dst;
    logic       pc_we;
    logic       pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       alu_imm;
    logic [5:0] ext;
    logic       e6;
    int         lat;
  } vec_t;

  typedef struct {
    vec_t       v;
    int         cnt;
    logic [2:0] nxt;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int   n_checks    = 0;
  int   n_fail      = 0;
  int   model_count = 0;
  int   cyc         = 0;
  int   fetch_delay = 0;
  int   mem_delay   = 0;
  logic [7:0] instr_byte = 8'h00;

  mc_control #(
    .MEM_TIMEOUT(8),
    .CNT_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir          (ir),
    .ext_data    (ext_data),
    .ext_is_6bits(ext_is_6bits),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .dst_sel     (dst_sel),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .mem_err     (mem_err),
    .state       (state)
  );

  // 10 ns clock and a free-running cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the design wedges the bench.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Memory responder: updates just after each rising edge. A new access
  // starts whenever mem_req rises or the previous access just completed.
  initial begin
    int acc;
    logic prev_req;
    acc       = 0;
    prev_req  = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (!prev_req || mem_ready) acc = 0;
        mem_rdata = addr_sel ? 8'hA5 : instr_byte;
        mem_ready = (acc >= (addr_sel ? mem_delay : fetch_delay));
        acc++;
      end else begin
        mem_ready = 1'b0;
        acc       = 0;
      end
      prev_req = mem_req;
    end
  end

  // Monitor: checks the fetch-completion PC update, measures instruction
  // latency and compares every instr_done cycle against the scoreboard.
  initial begin
    exp_t       e;
    int         start_cyc;
    logic [2:0] last_state;
    bit         pend;
    logic [2:0] pend_state;
    start_cyc  = 0;
    last_state = 3'd0;
    pend       = 1'b0;
    pend_state = 3'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend       = 1'b0;
        last_state = 3'd0;
      end else begin
        if (pend) begin
          checkOutput("next_state", state, pend_state);
          pend = 1'b0;
        end
        if (state == 3'd1 && last_state != 3'd1) start_cyc = cyc;
        last_state = state;
        if (state == 3'd1) begin
          checkOutput("fetch_pc_we", pc_we, mem_ready);
          checkOutput("fetch_pc_src", pc_src, 0);
        end
        if (instr_done) begin
          if (sb_q.size() == 0) begin
            checkOutput("spurious_done", instr_done, 0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("done_state", state, e.v.st);
            checkOutput("ir", ir, e.v.instr);
            checkOutput("reg_we", reg_we, e.v.reg_we);
            checkOutput("wb_sel", wb_sel, e.v.wb_sel);
            checkOutput("dst_sel", dst_sel, e.v.dst);
            checkOutput("pc_we", pc_we, e.v.pc_we);
            checkOutput("pc_src", pc_src, e.v.pc_src);
            checkOutput("mem_req", mem_req, e.v.mem_req);
            checkOutput("mem_we", mem_we, e.v.mem_we);
            checkOutput("addr_sel", addr_sel, e.v.mem_req);
            checkOutput("alu_src_imm", alu_src_imm, e.v.alu_imm);
            checkOutput("ext_data", ext_data, e.v.ext);
            checkOutput("ext_is_6bits", ext_is_6bits, e.v.e6);
            checkOutput("latency", cyc - start_cyc + 1, e.v.lat);
            checkOutput("instr_count", instr_count, e.cnt);
            pend       = 1'b1;
            pend_state = e.nxt;
          end
        end
      end
    end
  end

  // Issue one instruction: program the responder, record the expected
  // response, raise run, then drop run (unless chaining) once fetch starts.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   k;
    instr_byte  = v.instr;
    fetch_delay = v.fd;
    mem_delay   = v.md;
    e.v   = v;
    e.cnt = model_count;
    e.nxt = v.keep ? 3'd1 : 3'd0;
    sb_q.push_back(e);
    model_count = (model_count + 1) % 256;
    run = 1'b1;
    @(posedge clk);
    #1 run = v.keep;
    k = 0;
    @(negedge clk);
    while (!instr_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_seen", instr_done, 1);
    if (!v.keep) @(negedge clk);
  endtask

  initial begin
    int k;
    bit idle_ok;

    // instr fd md keep st reg_we wb_sel dst pc_we pc_src mem_req mem_we alu_imm ext e6 lat
    vecs[0] = '{8'h1B, 0, 0, 1'b0, 3'd5, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h1B, 1'b0, 4};
    vecs[1] = '{8'h46, 0, 3, 1'b0, 3'd5, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h06, 1'b0, 8};
    vecs[2] = '{8'h84, 1, 0, 1'b0, 3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h04, 1'b0, 5};
    vecs[3] = '{8'hFE, 2, 0, 1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3E, 1'b1, 4};
    vecs[4] = '{8'h01, 0, 0, 1'b0, 3'd5, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b0, 4};
    vecs[5] = '{8'h2E, 7, 0, 1'b0, 3'd5, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2E, 1'b0, 11};
    vecs[6] = '{8'h59, 0, 7, 1'b0, 3'd5, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h19, 1'b0, 12};
    vecs[7] = '{8'hB3, 0, 0, 1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h33, 1'b0, 4};
    vecs[8] = '{8'hC1, 0, 0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h01, 1'b1, 2};

    reset_n = 1'b0;
    run     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_ir", ir, 0);
    checkOutput("reset_count", instr_count, 0);
    checkOutput("reset_mem_err", mem_err, 0);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_ext_data", ext_data, 0);
    checkOutput("reset_ext_is_6bits", ext_is_6bits, 0);
    reset_n = 1'b1;

    // Ten cycles with run low: nothing may start.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_state", state, 0);
      checkOutput("idle_mem_req", mem_req, 0);
      checkOutput("idle_pc_we", pc_we, 0);
      checkOutput("idle_reg_we", reg_we, 0);
      checkOutput("idle_instr_done", instr_done, 0);
      checkOutput("idle_count", instr_count, 0);
    end

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Fetch timeout: memory never answers. Seven wait cycles are still
    // tolerated; the eighth raises mem_err and drops back to IDLE.
    instr_byte  = 8'h00;
    fetch_delay = 1000;
    run         = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_timeout_state", state, 1);
    checkOutput("pre_timeout_mem_err", mem_err, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_state", state, 0);
    checkOutput("timeout_mem_err", mem_err, 1);
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state != 3'd0 || mem_req != 1'b0 || instr_done != 1'b0) idle_ok = 1'b0;
    end
    checkOutput("err_blocks_run", idle_ok, 1);
    checkOutput("err_count_kept", instr_count, model_count);
    run = 1'b0;

    // Reset clears the sticky error.
    reset_n = 1'b0;
    #1;
    checkOutput("err_reset_mem_err", mem_err, 0);
    @(negedge clk);
    reset_n     = 1'b1;
    model_count = 0;

    // sw stalled in MEM, then an asynchronous reset between clock edges.
    instr_byte  = 8'h84;
    fetch_delay = 0;
    mem_delay   = 1000;
    run         = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    k = 0;
    @(negedge clk);
    while (state != 3'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("sw_in_mem", state, 4);
    checkOutput("sw_mem_req", mem_req, 1);
    checkOutput("sw_mem_we", mem_we, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_mem_req", mem_req, 0);
    checkOutput("async_mem_we", mem_we, 0);
    checkOutput("async_state", state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_state", state, 0);
    checkOutput("post_reset_count", instr_count, 0);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
